harmonic_scheduler: RTL and testbench
=====================================

Name: harmonic_scheduler

Overview:
Sequences the per-sample additive-synthesis datapath: sample-position lookups, the odd/even scaling adders, the harmonic-attenuation multiplier scaler and the DAC send. Runs one frame per sample interval and walks the harmonics 0..NO_OF_HARMONICS-1. It handshakes on every resource's ready/done signal and flags frames that overrun the sample deadline. Sits in top between the ADC-driven control registers and Sample_Position / Adder / Scale_Mult / Sample_Output.

Parameters:
SAMPLE_INTERVAL, 1000, Main_Clock cycles per output sample (48 MHz / 48 kHz)
NO_OF_HARMONICS, 50, harmonics per frame; last index NO_OF_HARMONICS-1; legal range 1..255
TIMER_W, 16, sample timer width; must satisfy SAMPLE_INTERVAL < 2^TIMER_W

Ports:
Main_Clock  in  1  system clock
Reset  in  1  reset Reset, synchronous, active-high; clock Main_Clock
i_Sample_Ready  in  1  Sample_Position has a valid value for o_Harmonic
i_Freq_Too_High  in  1  current harmonic exceeds Nyquist
i_Adder_Done  in  2  per-adder accumulate complete (bit0 even, bit1 odd)
i_Mult_Ready  in  1  scaler has produced the multiple for the current harmonic
i_Comb_Muted  in  1  current harmonic is muted by the comb filter
o_Harmonic  out  8  harmonic index being processed
o_Next_Sample  out  1  1-cycle request for a new sample-position lookup
o_Adder_Start  out  2  1-cycle start, one-hot, selected by o_Harmonic[0]
o_Adder_Clear  out  1  1-cycle accumulator clear
o_Mult_Start  out  1  1-cycle scaler step
o_Mult_Restart  out  1  1-cycle scaler reload to its initial value
o_Capture  out  1  1-cycle strobe; top latches both adder totals
o_DAC_Send  out  1  1-cycle strobe; start the DAC transfer of the captured totals
o_Overrun  out  1  sticky; set when a tick arrives mid-frame
o_Busy  out  1  high while a frame is being computed

Behaviour:
- Reset: all outputs 0, o_Harmonic=0, timer=0, abort=0, state=WAIT_TICK. Reset mid-frame abandons the frame with no o_Capture and no o_DAC_Send.
- Timer: counts 0..SAMPLE_INTERVAL-1 and wraps. tick = (timer==SAMPLE_INTERVAL-1), one cycle per interval, independent of state.
- WAIT_TICK: on tick, pulse o_DAC_Send, o_Mult_Restart and o_Next_Sample, set o_Harmonic=0, then go to SAMPLE_WAIT. o_Busy is 1 in every state except WAIT_TICK.
- SAMPLE_WAIT: wait for i_Sample_Ready. If muted (see Optional Feature), go to ADVANCE; otherwise go to ADDER_START.
- ADDER_START: pulse o_Adder_Start[o_Harmonic[0]], then go to ADDER_WAIT.
- ADDER_WAIT: wait for i_Adder_Done[o_Harmonic[0]], then go to ADVANCE.
- ADVANCE:
  - Go to CAPTURE if o_Harmonic==NO_OF_HARMONICS-1, or i_Freq_Too_High, or abort.
  - Otherwise increment o_Harmonic and pulse o_Next_Sample and o_Mult_Start in the same cycle, then go to MULT_WAIT.
- MULT_WAIT: wait for i_Mult_Ready, then go to SAMPLE_WAIT.
- CAPTURE: pulse o_Capture and o_Adder_Clear in the same cycle; top latches the pre-clear totals at that edge.
  - If abort is set, also pulse o_DAC_Send (late send) and clear abort.
  - Then go to WAIT_TICK.
- Overrun: a tick in any state other than WAIT_TICK sets o_Overrun (sticky until Reset) and sets abort. The frame is truncated at its next ADVANCE, with no new frame start.
- Tick in the same cycle that CAPTURE completes counts as an overrun; there is exactly one o_DAC_Send per tick.
- Every pulse output is high for exactly one cycle. At most one bit of o_Adder_Start is set.
- Handshake inputs are level-sampled; inputs that are held high do not retrigger because each wait state is left after one sample.

Optional Feature:
COMB_SKIP_EN
- Defined: in SAMPLE_WAIT, i_Comb_Muted=1 bypasses ADDER_START/ADDER_WAIT; no o_Adder_Start for that harmonic.
- Undefined: i_Comb_Muted is ignored and every harmonic is accumulated.

Decomposition:
- Shared package: state encoding localparams (WAIT_TICK, SAMPLE_WAIT, ADDER_START, ADDER_WAIT, ADVANCE, MULT_WAIT, CAPTURE), and SAMPLE_INTERVAL / NO_OF_HARMONICS defaults for reuse by top.
- One sub-module, sample_tick_timer: counter plus tick pulse, parameterised by SAMPLE_INTERVAL / TIMER_W.

Test Plan:
1. SAMPLE_INTERVAL=1000, NO_OF_HARMONICS=4, responders answer in 2 cycles -> o_Adder_Start pattern 01,10,01,10; one o_Capture; o_DAC_Send exactly 1000 cycles apart; o_Overrun=0.
2. i_Freq_Too_High asserted while o_Harmonic=2 -> CAPTURE after harmonic 2; no o_Adder_Start for harmonic 3; next frame restarts at 0.
3. Adder done delayed 300 cycles per harmonic (frame exceeds 1000) -> o_Overrun=1 at tick, frame truncated at next ADVANCE, late o_DAC_Send coincident with o_Capture, next frame starts at following tick.
4. COMB_SKIP_EN defined, i_Comb_Muted=1 for odd harmonics -> o_Adder_Start[1] never pulses; o_Mult_Start still pulses per harmonic; undefined build -> both adders pulse.
5. Reset asserted in ADDER_WAIT at harmonic 3 -> next cycle all outputs 0, o_Harmonic=0, no o_Capture or o_DAC_Send; first send exactly SAMPLE_INTERVAL cycles after Reset release.
6. i_Sample_Ready and i_Mult_Ready held high constantly -> each harmonic processed once; o_Next_Sample count per frame = NO_OF_HARMONICS.

Source files
------------

// File: rtl/harmonic_scheduler_pkg.sv
// Shared definitions for the harmonic scheduler: state encoding, default
// frame geometry and the adder-select helper.
package harmonic_scheduler_pkg;

  localparam int DEFAULT_SAMPLE_INTERVAL = 1000;
  localparam int DEFAULT_NO_OF_HARMONICS = 50;
  localparam int DEFAULT_TIMER_W         = 16;
  localparam int HARMONIC_W              = 8;

  typedef logic [2:0] state_t;

  localparam state_t WAIT_TICK   = 3'd0;
  localparam state_t SAMPLE_WAIT = 3'd1;
  localparam state_t ADDER_START = 3'd2;
  localparam state_t ADDER_WAIT  = 3'd3;
  localparam state_t ADVANCE     = 3'd4;
  localparam state_t MULT_WAIT   = 3'd5;
  localparam state_t CAPTURE     = 3'd6;

  // Even harmonics accumulate in adder 0, odd harmonics in adder 1.
  function automatic logic [1:0] adder_select(input logic parity);
    return parity ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/harmonic_scheduler_tick.sv
// Sample-rate timer: free-running 0..SAMPLE_INTERVAL-1 counter with a
// one-cycle tick on the last count, independent of the scheduler state.
module sample_tick_timer
  import harmonic_scheduler_pkg::*;
#(
  parameter int SAMPLE_INTERVAL = DEFAULT_SAMPLE_INTERVAL,
  parameter int TIMER_W         = DEFAULT_TIMER_W
) (
  input  logic Main_Clock,
  input  logic Reset,
  output logic tick_o
);

  localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(SAMPLE_INTERVAL - 1);

  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;

  // Wrap to zero after the last count of the interval.
  always_comb begin
    timer_d = (timer_q == LAST_COUNT) ? '0 : timer_q + TIMER_W'(1);
  end

  // Timer register.
  always_ff @(posedge Main_Clock) begin
    if (Reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign tick_o = (timer_q == LAST_COUNT);

endmodule

// File: rtl/harmonic_scheduler.sv
// Per-sample additive-synthesis sequencer. Each frame walks harmonics
// 0..NO_OF_HARMONICS-1 through sample lookup, adder accumulate and scaler
// step, then captures the totals for the DAC.
// Build option: define COMB_SKIP_EN to let i_Comb_Muted bypass the adders.
// All control outputs are registered, so a pulse and the o_Harmonic value it
// refers to appear in the same cycle.
module harmonic_scheduler
  import harmonic_scheduler_pkg::*;
#(
  parameter int SAMPLE_INTERVAL = DEFAULT_SAMPLE_INTERVAL,
  parameter int NO_OF_HARMONICS = DEFAULT_NO_OF_HARMONICS,
  parameter int TIMER_W         = DEFAULT_TIMER_W
) (
  input  logic                  Main_Clock,
  input  logic                  Reset,
  input  logic                  i_Sample_Ready,
  input  logic                  i_Freq_Too_High,
  input  logic [1:0]            i_Adder_Done,
  input  logic                  i_Mult_Ready,
  input  logic                  i_Comb_Muted,
  output logic [HARMONIC_W-1:0] o_Harmonic,
  output logic                  o_Next_Sample,
  output logic [1:0]            o_Adder_Start,
  output logic                  o_Adder_Clear,
  output logic                  o_Mult_Start,
  output logic                  o_Mult_Restart,
  output logic                  o_Capture,
  output logic                  o_DAC_Send,
  output logic                  o_Overrun,
  output logic                  o_Busy
);

  localparam logic [HARMONIC_W-1:0] LAST_HARMONIC = HARMONIC_W'(NO_OF_HARMONICS - 1);

  state_t                  state_q, state_d;
  logic [HARMONIC_W-1:0]   harmonic_q, harmonic_d;
  logic                    abort_q, abort_d;
  logic                    overrun_q, overrun_d;
  logic                    next_sample_q, next_sample_d;
  logic [1:0]              adder_start_q, adder_start_d;
  logic                    adder_clear_q, adder_clear_d;
  logic                    mult_start_q, mult_start_d;
  logic                    mult_restart_q, mult_restart_d;
  logic                    capture_q, capture_d;
  logic                    dac_send_q, dac_send_d;

  logic tick;
  logic muted;
  logic frame_end;

  sample_tick_timer #(
    .SAMPLE_INTERVAL(SAMPLE_INTERVAL),
    .TIMER_W        (TIMER_W)
  ) u_tick_timer (
    .Main_Clock(Main_Clock),
    .Reset     (Reset),
    .tick_o    (tick)
  );

`ifdef COMB_SKIP_EN
  assign muted = i_Comb_Muted;
`else
  logic unused_comb_muted;
  assign unused_comb_muted = i_Comb_Muted;
  assign muted = 1'b0;
`endif

  // A frame stops after the last harmonic, above Nyquist, or once it has
  // already missed its sample deadline.
  assign frame_end = (harmonic_q == LAST_HARMONIC) || i_Freq_Too_High || abort_q;

  // State and output registers.
  always_ff @(posedge Main_Clock) begin
    if (Reset) begin
      state_q        <= WAIT_TICK;
      harmonic_q     <= '0;
      abort_q        <= 1'b0;
      overrun_q      <= 1'b0;
      next_sample_q  <= 1'b0;
      adder_start_q  <= 2'b00;
      adder_clear_q  <= 1'b0;
      mult_start_q   <= 1'b0;
      mult_restart_q <= 1'b0;
      capture_q      <= 1'b0;
      dac_send_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      harmonic_q     <= harmonic_d;
      abort_q        <= abort_d;
      overrun_q      <= overrun_d;
      next_sample_q  <= next_sample_d;
      adder_start_q  <= adder_start_d;
      adder_clear_q  <= adder_clear_d;
      mult_start_q   <= mult_start_d;
      mult_restart_q <= mult_restart_d;
      capture_q      <= capture_d;
      dac_send_q     <= dac_send_d;
    end
  end

  // Next-state logic: every wait state leaves after a single sampled handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_TICK:   if (tick) state_d = SAMPLE_WAIT;
      SAMPLE_WAIT: if (i_Sample_Ready) state_d = muted ? ADVANCE : ADDER_START;
      ADDER_START: state_d = ADDER_WAIT;
      ADDER_WAIT:  if (i_Adder_Done[harmonic_q[0]]) state_d = ADVANCE;
      ADVANCE:     state_d = frame_end ? CAPTURE : MULT_WAIT;
      MULT_WAIT:   if (i_Mult_Ready) state_d = SAMPLE_WAIT;
      CAPTURE:     state_d = WAIT_TICK;
      default:     state_d = WAIT_TICK;
    endcase
  end

  // Output logic: pulses, harmonic index and overrun bookkeeping.
  always_comb begin
    harmonic_d     = harmonic_q;
    abort_d        = abort_q;
    overrun_d      = overrun_q;
    next_sample_d  = 1'b0;
    adder_start_d  = 2'b00;
    adder_clear_d  = 1'b0;
    mult_start_d   = 1'b0;
    mult_restart_d = 1'b0;
    capture_d      = 1'b0;
    dac_send_d     = 1'b0;

    // A tick while a frame is still running means the deadline was missed.
    if (tick && (state_q != WAIT_TICK)) begin
      overrun_d = 1'b1;
      abort_d   = 1'b1;
    end

    case (state_q)
      WAIT_TICK: begin
        if (tick) begin
          dac_send_d     = 1'b1;
          mult_restart_d = 1'b1;
          next_sample_d  = 1'b1;
          harmonic_d     = '0;
        end
      end
      ADDER_START: begin
        adder_start_d = adder_select(harmonic_q[0]);
      end
      ADVANCE: begin
        if (!frame_end) begin
          harmonic_d    = harmonic_q + HARMONIC_W'(1);
          next_sample_d = 1'b1;
          mult_start_d  = 1'b1;
        end
      end
      CAPTURE: begin
        capture_d     = 1'b1;
        adder_clear_d = 1'b1;
        // The send owed to a missed tick (earlier or this very cycle) goes
        // out late with the capture; abort is settled either way.
        if (abort_q || tick) dac_send_d = 1'b1;
        abort_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign o_Harmonic     = harmonic_q;
  assign o_Next_Sample  = next_sample_q;
  assign o_Adder_Start  = adder_start_q;
  assign o_Adder_Clear  = adder_clear_q;
  assign o_Mult_Start   = mult_start_q;
  assign o_Mult_Restart = mult_restart_q;
  assign o_Capture      = capture_q;
  assign o_DAC_Send     = dac_send_q;
  assign o_Overrun      = overrun_q;
  assign o_Busy         = (state_q != WAIT_TICK);

endmodule

// File: tb/tb_harmonic_scheduler.sv
// Scoreboard bench for harmonic_scheduler: randomized responders, a
// frame-level reference model that predicts the pulse sequence, and a
// monitor that checks every cycle in which the DUT raises a pulse.
module tb_harmonic_scheduler;

  localparam int SI = 1000;
  localparam int NH = 4;
  localparam int TW = 16;

`ifdef COMB_SKIP_EN
  localparam bit SKIP_BUILD = 1'b1;
`else
  localparam bit SKIP_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic       dac;
    logic       restart;
    logic       next;
    logic [1:0] astart;
    logic       clear;
    logic       mstart;
    logic       capture;
    logic       ovr;
    logic [7:0] h;
  } tok_t;

  logic       Main_Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       i_Sample_Ready = 1'b0;
  logic       i_Freq_Too_High = 1'b0;
  logic [1:0] i_Adder_Done = 2'b00;
  logic       i_Mult_Ready = 1'b0;
  logic       i_Comb_Muted = 1'b0;
  logic [7:0] o_Harmonic;
  logic       o_Next_Sample;
  logic [1:0] o_Adder_Start;
  logic       o_Adder_Clear;
  logic       o_Mult_Start;
  logic       o_Mult_Restart;
  logic       o_Capture;
  logic       o_DAC_Send;
  logic       o_Overrun;
  logic       o_Busy;

  harmonic_scheduler #(
    .SAMPLE_INTERVAL(SI),
    .NO_OF_HARMONICS(NH),
    .TIMER_W        (TW)
  ) dut (
    .Main_Clock     (Main_Clock),
    .Reset          (Reset),
    .i_Sample_Ready (i_Sample_Ready),
    .i_Freq_Too_High(i_Freq_Too_High),
    .i_Adder_Done   (i_Adder_Done),
    .i_Mult_Ready   (i_Mult_Ready),
    .i_Comb_Muted   (i_Comb_Muted),
    .o_Harmonic     (o_Harmonic),
    .o_Next_Sample  (o_Next_Sample),
    .o_Adder_Start  (o_Adder_Start),
    .o_Adder_Clear  (o_Adder_Clear),
    .o_Mult_Start   (o_Mult_Start),
    .o_Mult_Restart (o_Mult_Restart),
    .o_Capture      (o_Capture),
    .o_DAC_Send     (o_DAC_Send),
    .o_Overrun      (o_Overrun),
    .o_Busy         (o_Busy)
  );

  always #5 Main_Clock = ~Main_Clock;

  int   tests_run = 0;
  int   tests_failed = 0;
  tok_t exp_q[$];
  bit   check_en = 1'b0;
  int   cyc = 0;

  // Scenario knobs used by the responders.
  bit   hold_ready = 1'b0;
  int   adder_delay = 0;
  int   cutoff = 255;
  bit   mute_odd = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Reference model: the pulse sequence of one frame, derived from the
  // frame rules (start, per-harmonic accumulate/advance, capture).
  task automatic push_frame(input int cut, input bit mute, input int trunc,
                            input bit ovr_before, input bit ovr_frame);
    tok_t t;
    int   last;
    last = NH - 1;
    if (cut < last) last = cut;
    if (trunc < last) last = trunc;
    t = '0; t.dac = 1'b1; t.restart = 1'b1; t.next = 1'b1; t.ovr = ovr_before; t.h = 8'd0;
    exp_q.push_back(t);
    for (int h = 0; h <= last; h++) begin
      if (!(SKIP_BUILD && mute && (h % 2 == 1))) begin
        t = '0; t.astart = (h % 2 == 1) ? 2'b10 : 2'b01; t.ovr = ovr_before; t.h = 8'(h);
        exp_q.push_back(t);
      end
      if (h < last) begin
        t = '0; t.next = 1'b1; t.mstart = 1'b1; t.ovr = ovr_before; t.h = 8'(h + 1);
        exp_q.push_back(t);
      end
    end
    t = '0; t.capture = 1'b1; t.clear = 1'b1; t.dac = ovr_frame;
    t.ovr = ovr_before | ovr_frame; t.h = 8'(last);
    exp_q.push_back(t);
  endtask

  task automatic wait_drain(input string name, input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge Main_Clock);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Cycles since reset release, counted on the DUT's own clock edges.
  always @(posedge Main_Clock) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Responders: each ready/done level drops on a request and rises later.
  initial begin
    bit       s_rdy = 1'b0, m_rdy = 1'b0;
    int       s_cnt = 0, m_cnt = 0;
    logic [1:0] a_rdy = 2'b00;
    int       a_cnt [2] = '{0, 0};
    forever begin
      @(negedge Main_Clock);
      if (o_Next_Sample === 1'b1) begin
        s_rdy = 1'b0; s_cnt = $urandom_range(1, 6);
      end else if (s_cnt > 0) begin
        s_cnt--; if (s_cnt == 0) s_rdy = 1'b1;
      end
      if (o_Mult_Start === 1'b1 || o_Mult_Restart === 1'b1) begin
        m_rdy = 1'b0; m_cnt = $urandom_range(1, 6);
      end else if (m_cnt > 0) begin
        m_cnt--; if (m_cnt == 0) m_rdy = 1'b1;
      end
      for (int b = 0; b < 2; b++) begin
        if (o_Adder_Start[b] === 1'b1) begin
          a_rdy[b] = 1'b0;
          a_cnt[b] = (adder_delay > 0) ? adder_delay : int'($urandom_range(1, 6));
        end else if (a_cnt[b] > 0) begin
          a_cnt[b]--; if (a_cnt[b] == 0) a_rdy[b] = 1'b1;
        end
      end
      i_Sample_Ready  = hold_ready ? 1'b1 : s_rdy;
      i_Mult_Ready    = hold_ready ? 1'b1 : m_rdy;
      i_Adder_Done    = a_rdy;
      i_Freq_Too_High = (int'(o_Harmonic) >= cutoff);
      i_Comb_Muted    = mute_odd && (o_Harmonic[0] === 1'b1);
    end
  end

  // Monitor: every cycle with a pulse is matched against the next expectation.
  initial begin
    tok_t cur, want;
    forever begin
      @(negedge Main_Clock);
      if (!Reset && check_en) begin
        cur = {o_DAC_Send, o_Mult_Restart, o_Next_Sample, o_Adder_Start,
               o_Adder_Clear, o_Mult_Start, o_Capture, o_Overrun, o_Harmonic};
        if (cur[16:9] != 8'd0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'(cur), 32'd0);
          end else begin
            want = exp_q.pop_front();
            check("pulse_token", 32'(cur), 32'(want));
          end
          if (o_DAC_Send && !o_Capture) check("send_phase", 32'(cyc % SI), 32'd0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ovr_sticky;
    bit ovr_frame;
    int trunc;
    bit found;

    repeat (4) @(negedge Main_Clock);
    check("rst_pulses", 32'({o_DAC_Send, o_Mult_Restart, o_Next_Sample, o_Adder_Start,
                             o_Adder_Clear, o_Mult_Start, o_Capture}), 32'd0);
    check("rst_harmonic", 32'(o_Harmonic), 32'd0);
    check("rst_overrun", 32'(o_Overrun), 32'd0);
    check("rst_busy", 32'(o_Busy), 32'd0);

    ovr_sticky = 1'b0;
    for (int f = 0; f < 10; f++) begin
      cutoff = 255; mute_odd = 1'b0; hold_ready = 1'b0; adder_delay = 0;
      case (f)
        1: cutoff = 2;
        2: mute_odd = 1'b1;
        3: hold_ready = 1'b1;
        4: cutoff = 0;
        5: adder_delay = 400;
        7, 8, 9: begin
          cutoff = $urandom_range(0, 6);
          mute_odd = 1'($urandom_range(0, 1));
          hold_ready = 1'($urandom_range(0, 1));
        end
        default: ;
      endcase
      // With 400-cycle adders the deadline tick lands inside harmonic 2.
      ovr_frame = (f == 5);
      trunc = ovr_frame ? 2 : 255;
      push_frame(cutoff, mute_odd, trunc, ovr_sticky, ovr_frame);
      ovr_sticky = ovr_sticky | ovr_frame;
      if (f == 0) begin
        Reset = 1'b0;
        check_en = 1'b1;
      end
      wait_drain("frame_done", 3000);
    end
    check("overrun_sticky", 32'(o_Overrun), 32'd1);

    // Reset while harmonic 3 is waiting on its adder.
    check_en = 1'b0;
    adder_delay = 150;
    found = 1'b0;
    for (int i = 0; i < 2500 && !found; i++) begin
      @(negedge Main_Clock);
      if (o_Harmonic == 8'd3 && o_Adder_Start == 2'b10) found = 1'b1;
    end
    check("reach_h3_adder", 32'(found), 32'd1);
    repeat (3) @(negedge Main_Clock);
    check("busy_before_reset", 32'(o_Busy), 32'd1);
    Reset = 1'b1;
    @(negedge Main_Clock);
    check("midrst_pulses", 32'({o_DAC_Send, o_Mult_Restart, o_Next_Sample, o_Adder_Start,
                                o_Adder_Clear, o_Mult_Start, o_Capture}), 32'd0);
    check("midrst_harmonic", 32'(o_Harmonic), 32'd0);
    check("midrst_overrun", 32'(o_Overrun), 32'd0);
    check("midrst_busy", 32'(o_Busy), 32'd0);
    @(negedge Main_Clock);
    adder_delay = 0;
    push_frame(255, 1'b0, 255, 1'b0, 1'b0);
    Reset = 1'b0;
    check_en = 1'b1;
    for (int i = 0; i < 1200 && o_DAC_Send !== 1'b1; i++) @(negedge Main_Clock);
    check("first_send_cycle", 32'(cyc), 32'(SI));
    wait_drain("post_reset_frame", 1500);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
